fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_pkg.sv | 20 ++
 rtl/baud_counter.sv | 40 ++++
 rtl/fifo_uart_tx.sv | 135 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg
// Shared definitions for the FIFO-fed UART transmitter: the transmit FSM
// state encoding, word/byte widths and the default bit period.
package fifo_uart_pkg;

  localparam int DATA_W           = 16;  // width of one FIFO word
  localparam int BYTE_W           = 8;   // data bits per serial frame
  localparam int CLKS_PER_BIT_DEF = 16;  // default clocks per bit time
  localparam int BAUD_W           = 16;  // baud counter width (covers 65535)

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LATCH,
    START,
    DATA,
    STOP
  } state_e;

endpackage

// File: rtl/baud_counter.sv
// baud_counter
// Free-running bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps;
// tick_o marks the last cycle of every bit period.
// Ports:
//   clk     clock, rising edge
//   rst     synchronous reset, active low
//   clr_i   hold the count at zero (used while no frame is on the line)
//   tick_o  high during the final cycle of a bit period
module baud_counter
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [BAUD_W-1:0] CNT_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic [BAUD_W-1:0] cnt_q, cnt_d;
  logic              at_last;

  assign at_last = (cnt_q == CNT_LAST);
  assign tick_o  = at_last && !clr_i;

  always_comb begin
    cnt_d = cnt_q + BAUD_W'(1);
    // Wrapping on the tick lets consecutive bit periods run back to back
    // without the FSM reloading the counter.
    if (clr_i || at_last) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Pops 16-bit words from an upstream FIFO and sends each one as two 8N1
// UART frames, low byte first, then counts the completed word.
// Ports:
//   clk         clock, rising edge
//   rst         synchronous reset, active low
//   fifo_dout   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty  FIFO has no words (only looked at while idle)
//   fifo_rd_en  single-cycle pop strobe
//   tx          registered serial output, idle high
//   busy        high whenever a word is in progress
//   words_sent  wrapping count of fully transmitted words
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic [DATA_W-1:0] words_sent
);

  localparam int             BIT_W    = $clog2(BYTE_W);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BYTE_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              byte_q, byte_d;
  logic [DATA_W-1:0] words_sent_q, words_sent_d;
  logic              tx_q, tx_d;
  logic              baud_clr;
  logic              tick;

  baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clr_i (baud_clr),
    .tick_o(tick)
  );

  // State register and control counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      bit_q        <= '0;
      byte_q       <= 1'b0;
      words_sent_q <= '0;
      tx_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      words_sent_q <= words_sent_d;
      tx_q         <= tx_d;
    end
  end

  // Holding register is pure data; it is always reloaded before use.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    bit_d        = bit_q;
    byte_d       = byte_q;
    words_sent_d = words_sent_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = POP;
      end
      POP: begin
        state_d = LATCH;
      end
      LATCH: begin
        hold_d  = fifo_dout;
        byte_d  = 1'b0;
        bit_d   = '0;
        state_d = START;
      end
      START: begin
        if (tick) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == BIT_LAST) state_d = STOP;
          else                   bit_d   = bit_q + BIT_W'(1);
        end
      end
      STOP: begin
        if (tick) begin
          if (!byte_q) begin
            byte_d  = 1'b1;
            state_d = START;
          end else begin
            words_sent_d = words_sent_q + DATA_W'(1);
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. tx is decoded from the next state so the registered line
  // changes on the same edge the FSM enters a bit period.
  always_comb begin
    fifo_rd_en = (state_q == POP);
    busy       = (state_q != IDLE);
    baud_clr   = (state_q == IDLE) || (state_q == POP) || (state_q == LATCH);
    tx_d       = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = hold_d[{byte_d, bit_d}];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx         = tx_q;
  assign words_sent = words_sent_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] fifo_dout = 16'h0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        tx;
  logic        busy;
  logic [15:0] words_sent;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] fq[$];      // upstream FIFO contents
  logic [15:0] exp_q[$];   // words popped, awaiting serial reception
  int          pop_cyc[$];
  int          last_pop = -100;
  logic [15:0] exp_ws = 16'h0;
  logic        emp_m = 1'b1;
  logic        tgl = 1'b0;
  logic        prev_rd = 1'b0;

  assign fifo_empty = emp_m ^ tgl;

  fifo_uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .tx        (tx),
    .busy      (busy),
    .words_sent(words_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    fq.push_back(w);
    emp_m = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(fq.size() == 0 && exp_q.size() == 0 && busy === 1'b0 &&
                 fifo_rd_en === 1'b0) && k < budget);
    chk("idle_reached", (k < budget), 1);
  endtask

  task automatic wait_pop(input int n, input int budget);
    int k;
    k = 0;
    while (pop_cyc.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("pop_seen", (pop_cyc.size() >= n), 1);
  endtask

  // Upstream FIFO model: serves a word on each pop and records expectations.
  initial begin : fifo_model
    forever begin
      @(negedge clk);
      if (fifo_rd_en === 1'b1) begin
        chk("rd_single", prev_rd, 0);
        chk("pop_nonempty", (fq.size() != 0), 1);
        if (fq.size() != 0) begin
          fifo_dout = fq.pop_front();
          exp_q.push_back(fifo_dout);
          emp_m = (fq.size() == 0);
        end
        pop_cyc.push_back(cyc);
        last_pop = cyc;
      end
      prev_rd = fifo_rd_en;
    end
  end

  // Receives one 8N1 frame; called on the first start-bit cycle.
  task automatic rx_byte(output bit ok, output logic [7:0] v);
    ok = 1'b1;
    v  = 8'h0;
    for (int c = 1; c < 10 * N; c++) begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        ok = 1'b0;
        break;
      end
      if (c % N == N / 2) begin
        if (c / N == 0)      chk("start_bit", tx, 0);
        else if (c / N <= 8) v[c / N - 1] = tx;
        else                 chk("stop_bit", tx, 1);
      end
    end
  endtask

  // Serial monitor: decodes the line and scores each word against the queue.
  initial begin : monitor
    logic [7:0]  b0, b1;
    logic [15:0] w;
    bit          ok;
    b1 = 8'h0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        exp_q.delete();
        exp_ws = 16'h0;
      end else if (tx === 1'b0) begin
        chk("start_after_pop", cyc - last_pop, 2);
        rx_byte(ok, b0);
        if (ok) begin
          @(negedge clk);
          if (rst !== 1'b1) ok = 1'b0;
          else begin
            chk("second_start_gap", tx, 0);
            if (tx === 1'b0) rx_byte(ok, b1);
            else             ok = 1'b0;
          end
        end
        if (ok) begin
          @(negedge clk);
          if (rst !== 1'b1) ok = 1'b0;
        end
        if (ok) begin
          w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
          chk("word", {b1, b0}, w);
          exp_ws = exp_ws + 16'd1;
          chk("words_sent", words_sent, exp_ws);
          chk("busy_end", busy, 0);
        end else begin
          exp_q.delete();
          exp_ws = 16'h0;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int n;
    int p;
    int rel;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_words_sent", words_sent, 0);
    rst = 1'b1;

    // Empty FIFO: line must stay idle.
    n = 0;
    repeat (200) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) n++;
    end
    chk("idle_200", n, 0);

    // Single word.
    pop_cyc.delete();
    push_word(16'h1234);
    wait_idle(300);
    chk("pops_1234", pop_cyc.size(), 1);
    chk("ws_1234", words_sent, 1);

    // Back-to-back words.
    pop_cyc.delete();
    push_word(16'h0001);
    push_word(16'h0002);
    wait_idle(400);
    chk("pops_b2b", pop_cyc.size(), 2);
    chk("pop_spacing", (pop_cyc.size() == 2) ? pop_cyc[1] - pop_cyc[0] : -1, 20 * N + 3);
    chk("ws_b2b", words_sent, 3);

    // fifo_empty wiggles during DATA must not cause a pop.
    pop_cyc.delete();
    push_word(16'h00FF);
    wait_pop(1, 20);
    p = (pop_cyc.size() > 0) ? pop_cyc[0] : cyc;
    while (cyc < p + 3 + N) @(negedge clk);
    repeat (8 * N - 3) begin
      tgl = ~tgl;
      @(negedge clk);
    end
    tgl = 1'b0;
    wait_idle(300);
    chk("pops_toggle", pop_cyc.size(), 1);
    chk("ws_toggle", words_sent, 4);

    // Random words with random gaps.
    pop_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      push_word(16'($urandom));
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    wait_idle(1500);
    chk("pops_rand", pop_cyc.size(), 6);
    chk("ws_rand", words_sent, 10);

    // Reset 30 cycles into a word.
    pop_cyc.delete();
    push_word(16'hABCD);
    wait_pop(1, 20);
    p = (pop_cyc.size() > 0) ? pop_cyc[0] : cyc;
    while (cyc < p + 2 + 30) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_ws", words_sent, 0);
    chk("midrst_rd_en", fifo_rd_en, 0);
    push_word(16'h5A5A);
    @(negedge clk);
    rst = 1'b1;
    rel = cyc;
    wait_pop(2, 20);
    chk("pop_after_release", (pop_cyc.size() >= 2) ? pop_cyc[1] - rel : -1, 1);
    wait_idle(300);
    chk("ws_after_rst", words_sent, 1);

    // Counter wrap.
    force dut.words_sent_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.words_sent_q;
    exp_ws = 16'hFFFF;
    @(negedge clk);
    chk("ws_preset", words_sent, 16'hFFFF);
    push_word(16'hC3A5);
    wait_idle(300);
    chk("ws_wrap", words_sent, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
